counter_mod: RTL



---
 rtl/counter_mod.sv | 101 ++++++++++
 1 files changed

// File: rtl/counter_mod.sv
`default_nettype none
// ============================================================================
// Module  : counter_mod
// Brief   : Programmable-modulus up/down counter with prescaler, wrap or
//           saturate at terminal, and terminal/wrap/sticky-overflow status.
// Rev     : 1.0  initial release
// ============================================================================
module counter_mod #(
  parameter int unsigned     W         = 32,
  parameter longint unsigned MOD       = 0,
  parameter logic [W-1:0]    RESET_VAL = '0,
  parameter int unsigned     PRESCALE  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         sat_mode,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         ovf_clr,
  output logic [W-1:0] value,
  output logic         tc,
  output logic         wrap,
  output logic         ovf_sticky
);

  // Terminal value is computed in W bits so W=32, MOD=0 never needs 2^W.
  localparam logic [W-1:0] c_TOP      = (MOD == 0) ? {W{1'b1}} : W'(MOD - 1);
  localparam int           c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);

  logic [W-1:0]    value_q, value_d;
  logic [c_PW-1:0] pre_q,   pre_d;
  logic            wrap_q,  wrap_d;
  logic            ovf_q,   ovf_d;

  always_comb begin
    value_d = value_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~ovf_clr;

    if (clr) begin
      value_d = '0;
      pre_d   = '0;
    end else if (load) begin
      value_d = (load_val > c_TOP) ? c_TOP : load_val;
      pre_d   = '0;
    end else if (en) begin
      if (pre_q == c_PRE_LAST) begin
        pre_d = '0;
        if (dir) begin
          if (value_q == c_TOP) begin
            ovf_d = 1'b1;
            if (!sat_mode) begin
              value_d = '0;
              wrap_d  = 1'b1;
            end
          end else begin
            value_d = value_q + 1'b1;
          end
        end else begin
          if (value_q == '0) begin
            ovf_d = 1'b1;
            if (!sat_mode) begin
              value_d = c_TOP;
              wrap_d  = 1'b1;
            end
          end else begin
            value_d = value_q - 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= RESET_VAL;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value      = value_q;
  assign tc         = dir ? (value_q == c_TOP) : (value_q == '0);
  assign wrap       = wrap_q;
  assign ovf_sticky = ovf_q;

endmodule
`default_nettype wire
